// File: rtl/key_event_debouncer.sv
// key_event_debouncer
// Debounces a raw key-down level plus key code into clean press/release
// events, a debounced "held" level, the last accepted code and a wrapping
// press counter. Optional auto-repeat while the key stays down.
//
// Build option: define KEY_REPEAT_EN to include the auto-repeat timer.
// Without it repeat_pulse is tied low and REPEAT_DELAY/REPEAT_PERIOD
// are only range-checked.
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous, active-high
//   key_valid     raw key-down level (already synchronised to clk)
//   code_in       raw key code, meaningful while key_valid=1
//   code_out      last debounced pressed code
//   press_pulse   one-cycle pulse on an accepted press
//   release_pulse one-cycle pulse on an accepted release
//   held          key debounced down
//   repeat_pulse  one-cycle auto-repeat pulse
//   press_count   accepted presses, wraps modulo 2^COUNT_W
//
// state       | meaning
// ------------+--------------------------------------------------
// IDLE        | key up, waiting for key_valid
// DEB_PRESS   | key seen down, counting stable samples of candidate
// HELD        | press accepted, key debounced down
// DEB_RELEASE | key seen up while held, counting stable low samples

module key_event_debouncer #(
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 960000,
  parameter int COUNT_W         = 8,
  parameter int REPEAT_DELAY    = 24000000,
  parameter int REPEAT_PERIOD   = 6000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [CODE_W-1:0]  code_in,
  output logic [CODE_W-1:0]  code_out,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               held,
  output logic               repeat_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_event_debouncer: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CODE_W-1:0]  cand, cand_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic               press_nxt, release_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cand          <= '0;
      code_out      <= '0;
      press_count   <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      cand          <= cand_nxt;
      code_out      <= code_nxt;
      press_count   <= count_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // One counter serves both debounce directions; it is cleared on every
  // entry into a debounce state and on every code change while pressing.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand;
    code_nxt    = code_out;
    count_nxt   = press_count;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          state_nxt = DEB_PRESS;
          cnt_nxt   = '0;
          cand_nxt  = code_in;
        end
      end
      DEB_PRESS: begin
        if (!key_valid) begin
          state_nxt = IDLE;
        end else if (code_in != cand) begin
          cand_nxt = code_in;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          code_nxt  = cand;
          press_nxt = 1'b1;
          count_nxt = press_count + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!key_valid) begin
          state_nxt = DEB_RELEASE;
          cnt_nxt   = '0;
        end
      end
      DEB_RELEASE: begin
        if (key_valid) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign held = (state == HELD) || (state == DEB_RELEASE);

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_target;
  logic             rep_armed;
  logic             rep_pulse_q;

  // rep_armed selects between the initial delay and the repeat period.
  assign rep_target = rep_armed ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt     <= '0;
      rep_armed   <= 1'b0;
      rep_pulse_q <= 1'b0;
    end else if (press_nxt) begin
      rep_cnt     <= '0;
      rep_armed   <= 1'b0;
      rep_pulse_q <= 1'b0;
    end else if (state == HELD) begin
      if (rep_cnt == rep_target) begin
        rep_cnt     <= '0;
        rep_armed   <= 1'b1;
        rep_pulse_q <= 1'b1;
      end else begin
        rep_cnt     <= rep_cnt + 1'b1;
        rep_pulse_q <= 1'b0;
      end
    end else begin
      rep_pulse_q <= 1'b0;
    end
  end

  assign repeat_pulse = rep_pulse_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
